// File: rtl/cfglut5_loader.sv
`default_nettype none
// ============================================================================
// Module      : cfglut5_loader
// Description : Serial configuration loader for a cascade of NUM_LUTS CFGLUT5
//               cells. Accepts a W-bit truth-table image over valid/ready,
//               shifts it MSB-first into the chain via CE/CDI for exactly W
//               enabled cycles, and captures the displaced old chain contents
//               from the last cell's CDO for readback.
// Ports       :
//   CLK       - clock (rising edge; also clocks the CFGLUT5 chain)
//   RST       - synchronous active-high reset
//   IN_VALID  - new image available
//   IN_READY  - loader can accept an image (IDLE)
//   IN_DATA   - image; bits [32k+31:32k] become the INIT of LUT k
//   HOLD      - pause shifting while high
//   CE        - chain clock enable
//   CDI       - serial data into LUT 0
//   CDO       - serial data out of LUT NUM_LUTS-1
//   BUSY      - high in SHIFT and DONE
//   DONE      - one-cycle completion pulse
//   OLD_DATA  - previous chain image, same mapping as IN_DATA
// Revision    : 1.0 - initial release
// ============================================================================
module cfglut5_loader #(
  parameter int NUM_LUTS = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [32*NUM_LUTS-1:0]  IN_DATA,
  input  logic                    HOLD,
  output logic                    CE,
  output logic                    CDI,
  input  logic                    CDO,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [32*NUM_LUTS-1:0]  OLD_DATA
);

  localparam int W     = 32 * NUM_LUTS;
  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  if ((NUM_LUTS < 1) || (NUM_LUTS > 8)) begin : g_bad_num_luts
    $error("cfglut5_loader: NUM_LUTS must be in 1..8");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [W-1:0]       shreg_q;
  logic [W-1:0]       old_q;
  logic [CNT_W-1:0]   cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      old_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (IN_VALID) begin
            shreg_q <= IN_DATA;
            cnt_q   <= CNT_LOAD;
            old_q   <= '0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // The chain shifts on this same edge (CE=!HOLD), so CDO still shows
          // the pre-shift top bit of the last cell: capture it now.
          if (!HOLD) begin
            shreg_q <= {shreg_q[W-2:0], 1'b0};
            old_q   <= {old_q[W-2:0], CDO};
            cnt_q   <= cnt_q - 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // All outputs decode the state register; only CE also looks at HOLD so a
  // paused cycle never advances the chain.
  assign IN_READY = (state_q == S_IDLE);
  assign BUSY     = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign DONE     = (state_q == S_DONE);
  assign CE       = (state_q == S_SHIFT) && !HOLD;
  assign CDI      = (state_q == S_SHIFT) && shreg_q[W-1];
  assign OLD_DATA = old_q;

endmodule
`default_nettype wire

// File: tb/tb_cfglut5_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfglut5_loader
// Description : Directed self-checking bench for cfglut5_loader. Two loader
//               instances (1 LUT and 3 LUTs) each drive a behavioural CFGLUT5
//               chain; chain contents, CE/CDI activity, timing and readback
//               are compared with hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfglut5_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 1-LUT instance
  logic        v1, rdy1, hold1, ce1, cdi1, cdo1, busy1, done1;
  logic [31:0] d1, old1;
  // 3-LUT instance
  logic        v3, rdy3, hold3, ce3, cdi3, cdo3, busy3, done3;
  logic [95:0] d3, old3;

  cfglut5_loader #(.NUM_LUTS(1)) u_dut1 (
    .CLK(clk), .RST(rst), .IN_VALID(v1), .IN_READY(rdy1), .IN_DATA(d1),
    .HOLD(hold1), .CE(ce1), .CDI(cdi1), .CDO(cdo1), .BUSY(busy1),
    .DONE(done1), .OLD_DATA(old1)
  );

  cfglut5_loader #(.NUM_LUTS(3)) u_dut3 (
    .CLK(clk), .RST(rst), .IN_VALID(v3), .IN_READY(rdy3), .IN_DATA(d3),
    .HOLD(hold3), .CE(ce3), .CDI(cdi3), .CDO(cdo3), .BUSY(busy3),
    .DONE(done3), .OLD_DATA(old3)
  );

  // Behavioural CFGLUT5 chains: r <= {r[30:0], CDI} when CE, CDO = r[31].
  logic [31:0] lut1   = '0;
  logic [31:0] lut3_0 = '0;
  logic [31:0] lut3_1 = '0;
  logic [31:0] lut3_2 = '0;

  always @(posedge clk) begin
    if (ce1) lut1 <= {lut1[30:0], cdi1};
  end
  assign cdo1 = lut1[31];

  always @(posedge clk) begin
    if (ce3) begin
      lut3_0 <= {lut3_0[30:0], cdi3};
      lut3_1 <= {lut3_1[30:0], lut3_0[31]};
      lut3_2 <= {lut3_2[30:0], lut3_1[31]};
    end
  end
  assign cdo3 = lut3_2[31];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_value(input string tag, input logic [95:0] obs,
                             input logic [95:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One load on the 1-LUT instance. Returns CE count, cycle index (after the
  // accept edge) of the DONE pulse, the CDI bit stream and whether IN_READY
  // was seen high between accept and DONE. Ends inside the DONE cycle.
  task automatic run1(input logic [31:0] img, input int hold_at,
                      input int hold_len, input bit hold_final,
                      input int pulse_at, output int ce_cnt,
                      output int done_cyc, output logic [31:0] cdi_seq,
                      output bit ready_seen);
    int held;
    bit final_held;
    ce_cnt = 0; done_cyc = -1; cdi_seq = '0; ready_seen = 0;
    held = 0; final_held = 0;
    v1 = 1'b1; d1 = img;
    @(posedge clk); #1;
    v1 = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      hold1 = 1'b0;
      v1    = 1'b0;
      if (hold_len > 0 && ce_cnt == hold_at && held < hold_len) begin
        hold1 = 1'b1; held++;
      end else if (hold_final && ce_cnt == 31 && !final_held) begin
        hold1 = 1'b1; final_held = 1;
      end
      if (pulse_at >= 0 && ce_cnt == pulse_at) begin
        v1 = 1'b1; d1 = ~img;
      end
      #1;
      if (ce1) begin
        cdi_seq = {cdi_seq[30:0], cdi1};
        ce_cnt++;
      end
      if (rdy1) ready_seen = 1;
      if (done1) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    hold1 = 1'b0;
    v1    = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ce_cnt, done_cyc, acc, n;
    logic [31:0] seq, snap;
    bit          rs, dseen;

    rst = 1'b1;
    v1 = 1'b0; d1 = '0; hold1 = 1'b0;
    v3 = 1'b0; d3 = '0; hold3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check_value("rst_ready", 96'(rdy1), 96'(1));
    check_value("rst_ce",    96'(ce1),  96'(0));
    check_value("rst_cdi",   96'(cdi1), 96'(0));
    check_value("rst_busy",  96'(busy1), 96'(0));
    check_value("rst_done",  96'(done1), 96'(0));
    check_value("rst_old",   96'(old1), 96'(0));
    check_value("rst3_ready", 96'(rdy3), 96'(1));
    rst = 1'b0;
    @(posedge clk); #1;

    // Test 1: basic load over a zero chain
    run1(32'hCAFEF00D, -1, 0, 1'b0, -1, ce_cnt, done_cyc, seq, rs);
    check_value("t1_ce_count", 96'(ce_cnt), 96'(32));
    check_value("t1_cdi_seq",  96'(seq),  96'(32'hCAFEF00D));
    check_value("t1_done_cyc", 96'(done_cyc), 96'(33));
    check_value("t1_busy_in_done", 96'(busy1), 96'(1));
    check_value("t1_ce_in_done",   96'(ce1),   96'(0));
    check_value("t1_lut",      96'(lut1), 96'(32'hCAFEF00D));
    check_value("t1_o6_i0",    96'(lut1[0]), 96'(1));
    check_value("t1_old",      96'(old1), 96'(0));
    @(posedge clk); #1;
    check_value("t1_ready_after", 96'(rdy1), 96'(1));

    // Test 2: back-to-back with IN_VALID held
    v1 = 1'b1; d1 = 32'h12345678;
    @(posedge clk); #1;
    d1 = 32'h9ABCDEF0;
    acc = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (rdy1) begin
        acc = k + 1;
        break;
      end
    end
    check_value("t2_second_accept_edge", 96'(acc), 96'(34));
    check_value("t2_first_old", 96'(old1), 96'(32'hCAFEF00D));
    @(posedge clk); #1;
    v1 = 1'b0;
    check_value("t2_busy_after_accept", 96'(busy1), 96'(1));
    dseen = 0;
    for (int k = 0; k < 100; k++) begin
      if (done1) begin
        dseen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check_value("t2_done_seen", 96'(dseen), 96'(1));
    check_value("t2_old", 96'(old1), 96'(32'h12345678));
    check_value("t2_lut", 96'(lut1), 96'(32'h9ABCDEF0));
    @(posedge clk); #1;

    // Test 4: HOLD for 5 cycles after 10 CE cycles, and once on the last bit
    run1(32'h3C5A96E1, 10, 5, 1'b1, -1, ce_cnt, done_cyc, seq, rs);
    check_value("t4_ce_count", 96'(ce_cnt), 96'(32));
    check_value("t4_done_cyc", 96'(done_cyc), 96'(39));
    check_value("t4_lut", 96'(lut1), 96'(32'h3C5A96E1));
    check_value("t4_old", 96'(old1), 96'(32'h9ABCDEF0));
    @(posedge clk); #1;

    // Test 6: IN_VALID pulse with different data mid-shift is ignored
    run1(32'h600DBEEF, -1, 0, 1'b0, 8, ce_cnt, done_cyc, seq, rs);
    check_value("t6_ce_count", 96'(ce_cnt), 96'(32));
    check_value("t6_done_cyc", 96'(done_cyc), 96'(33));
    check_value("t6_ready_while_busy", 96'(rs), 96'(0));
    check_value("t6_lut", 96'(lut1), 96'(32'h600DBEEF));
    check_value("t6_old", 96'(old1), 96'(32'h3C5A96E1));
    @(posedge clk); #1;
    check_value("t6_ready_after_done", 96'(rdy1), 96'(1));

    // Test 5: reset after 16 CE cycles
    v1 = 1'b1; d1 = 32'hA5A5A5A5;
    @(posedge clk); #1;
    v1 = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (ce1) n++;
      if (n >= 16) break;
      @(posedge clk); #1;
    end
    check_value("t5_ce_before_rst", 96'(n), 96'(16));
    rst = 1'b1;
    @(posedge clk); #1;
    check_value("t5_ce",    96'(ce1),   96'(0));
    check_value("t5_ready", 96'(rdy1),  96'(1));
    check_value("t5_busy",  96'(busy1), 96'(0));
    check_value("t5_old",   96'(old1),  96'(0));
    rst = 1'b0;
    dseen = done1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done1) dseen = 1;
    end
    check_value("t5_no_done", 96'(dseen), 96'(0));
    snap = lut1;
    run1(32'h0F0F0F0F, -1, 0, 1'b0, -1, ce_cnt, done_cyc, seq, rs);
    check_value("t5_reload_ce",   96'(ce_cnt), 96'(32));
    check_value("t5_reload_done", 96'(done_cyc), 96'(33));
    check_value("t5_reload_lut",  96'(lut1), 96'(32'h0F0F0F0F));
    check_value("t5_reload_old",  96'(old1), 96'(snap));
    @(posedge clk); #1;

    // Test 3: three-LUT chain
    v3 = 1'b1; d3 = {32'hAAAAAAAA, 32'h55555555, 32'hFFFF0000};
    @(posedge clk); #1;
    v3 = 1'b0;
    ce_cnt = 0; done_cyc = -1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (ce3) ce_cnt++;
      if (done3) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    check_value("t3_ce_count", 96'(ce_cnt), 96'(96));
    check_value("t3_done_cyc", 96'(done_cyc), 96'(97));
    check_value("t3_lut2", 96'(lut3_2), 96'(32'hAAAAAAAA));
    check_value("t3_lut1", 96'(lut3_1), 96'(32'h55555555));
    check_value("t3_lut0", 96'(lut3_0), 96'(32'hFFFF0000));
    check_value("t3_old",  old3, 96'(0));
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
